cardinal_input_port: RTL and testbench

//  Router input port; the stage directly downstream of cardinal_nic's net_so/net_ro/net_do link (and of peer output ports).

---
 rtl/cardinal_pkg.sv | 15 +
 rtl/xy_route_calc.sv | 29 ++
 rtl/cardinal_input_port.sv | 86 ++++++++
 tb/tb_cardinal_input_port.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cardinal_pkg.sv
// rtl/cardinal_pkg.sv - flit field positions and switch port one-hot encodings
package cardinal_pkg;
  localparam int VC_BIT = 63;
  localparam int DX_BIT = 62;
  localparam int DY_BIT = 61;
  localparam int HX_LSB = 48;
  localparam int HY_LSB = 40;
  localparam int HOP_W  = 8;

  localparam logic [4:0] P_EAST  = 5'b00001;
  localparam logic [4:0] P_WEST  = 5'b00010;
  localparam logic [4:0] P_NORTH = 5'b00100;
  localparam logic [4:0] P_SOUTH = 5'b01000;
  localparam logic [4:0] P_PE    = 5'b10000;
endpackage

// File: rtl/xy_route_calc.sv
// rtl/xy_route_calc.sv - combinational XY routing: one-hot port request plus hop-decremented flit
module xy_route_calc
  import cardinal_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] flit_i,
  output logic [4:0]        req_o,
  output logic [DATA_W-1:0] flit_o
);
  logic [HOP_W-1:0] hx;
  logic [HOP_W-1:0] hy;

  assign hx = flit_i[HX_LSB +: HOP_W];
  assign hy = flit_i[HY_LSB +: HOP_W];

  // X is exhausted before Y; only a nonzero field is decremented, so hops never wrap
  always_comb begin
    req_o  = P_PE;
    flit_o = flit_i;
    if (hx != '0) begin
      req_o                    = flit_i[DX_BIT] ? P_WEST : P_EAST;
      flit_o[HX_LSB +: HOP_W]  = hx - HOP_W'(1);
    end else if (hy != '0) begin
      req_o                    = flit_i[DY_BIT] ? P_SOUTH : P_NORTH;
      flit_o[HY_LSB +: HOP_W]  = hy - HOP_W'(1);
    end
  end
endmodule

// File: rtl/cardinal_input_port.sv
// rtl/cardinal_input_port.sv - two-VC router input port; link fills VC !polarity, switch drains VC polarity
module cardinal_input_port
  import cardinal_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              si,
  output logic              ri,
  input  logic [DATA_W-1:0] di,
  output logic [4:0]        req,
  input  logic              gnt,
  output logic [DATA_W-1:0] do_flit,
  output logic              err_vc,
  output logic [CNT_W-1:0]  flit_cnt
);
  logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic              full0_q, full0_d, full1_q, full1_d;
  logic              err_vc_q, err_vc_d;
  logic [CNT_W-1:0]  flit_cnt_q, flit_cnt_d;

  logic              vc_in, accept, drain, sel_full;
  logic [DATA_W-1:0] sel_buf, rt_flit;
  logic [4:0]        rt_req;

  assign vc_in    = di[VC_BIT];
  assign ri       = polarity ? ~full0_q : ~full1_q;
  assign accept   = si & ri & (vc_in != polarity);
  assign sel_buf  = polarity ? buf1_q : buf0_q;
  assign sel_full = polarity ? full1_q : full0_q;

  xy_route_calc #(.DATA_W(DATA_W)) u_route (
    .flit_i (sel_buf),
    .req_o  (rt_req),
    .flit_o (rt_flit)
  );

  assign req      = sel_full ? rt_req : 5'b0;
  assign do_flit  = sel_full ? rt_flit : '0;
  assign drain    = gnt & (|req);
  assign err_vc   = err_vc_q;
  assign flit_cnt = flit_cnt_q;

  // accept targets VC !polarity and drain targets VC polarity, so both may land on one edge
  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    full0_d    = full0_q;
    full1_d    = full1_q;
    err_vc_d   = err_vc_q | (si & ~accept);
    flit_cnt_d = flit_cnt_q;
    if (drain && !polarity) full0_d = 1'b0;
    if (drain && polarity)  full1_d = 1'b0;
    if (accept) begin
      if (vc_in) begin
        buf1_d  = di;
        full1_d = 1'b1;
      end else begin
        buf0_d  = di;
        full0_d = 1'b1;
      end
      if (flit_cnt_q != '1) flit_cnt_d = flit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      full0_q    <= 1'b0;
      full1_q    <= 1'b0;
      err_vc_q   <= 1'b0;
      flit_cnt_q <= '0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      full0_q    <= full0_d;
      full1_q    <= full1_d;
      err_vc_q   <= err_vc_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end
endmodule

// File: tb/tb_cardinal_input_port.sv
// tb/tb_cardinal_input_port.sv - directed bench with per-VC scoreboard for cardinal_input_port
module tb_cardinal_input_port;
  logic        clk = 1'b0;
  logic        reset, polarity, si, gnt;
  logic [63:0] di;
  logic        ri, err_vc;
  logic [4:0]  req;
  logic [63:0] do_flit;
  logic [15:0] flit_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0]  m_full;
  logic        m_err;
  logic [15:0] m_cnt;
  logic [68:0] q0[$];
  logic [68:0] q1[$];
  logic [63:0] held;
  logic [15:0] cnt_save;

  always #5 clk = ~clk;

  cardinal_input_port dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .si       (si),
    .ri       (ri),
    .di       (di),
    .req      (req),
    .gnt      (gnt),
    .do_flit  (do_flit),
    .err_vc   (err_vc),
    .flit_cnt (flit_cnt)
  );

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach end of sequence");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] mk(input logic vc, input logic dx, input logic dy,
                                     input logic [7:0] hx, input logic [7:0] hy,
                                     input logic [39:0] pay);
    return {vc, dx, dy, 5'b0, hx, hy, pay};
  endfunction

  function automatic logic [68:0] exp_route(input logic [63:0] f);
    logic [63:0] o;
    logic [4:0]  r;
    o = f;
    if (f[55:48] != 8'd0) begin
      r = f[62] ? 5'b00010 : 5'b00001;
      o[55:48] = f[55:48] - 8'd1;
    end else if (f[47:40] != 8'd0) begin
      r = f[61] ? 5'b01000 : 5'b00100;
      o[47:40] = f[47:40] - 8'd1;
    end else begin
      r = 5'b10000;
    end
    return {r, o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [68:0] front;
    chk("ri", {63'b0, ri}, {63'b0, ~m_full[~polarity]});
    chk("err_vc", {63'b0, err_vc}, {63'b0, m_err});
    chk("flit_cnt", {48'b0, flit_cnt}, {48'b0, m_cnt});
    if (m_full[polarity]) begin
      front = polarity ? q1[0] : q0[0];
      chk("sb_req", {59'b0, req}, {59'b0, front[68:64]});
      chk("sb_do_flit", do_flit, front[63:0]);
    end else begin
      chk("idle_req", {59'b0, req}, 64'd0);
      chk("idle_do_flit", do_flit, 64'd0);
    end
  endtask

  task automatic tick();
    logic acc, drn, vc;
    vc  = di[63];
    acc = si && !m_full[~polarity] && (vc != polarity);
    drn = gnt && m_full[polarity];
    if (si && !acc) m_err = 1'b1;
    if (drn) begin
      m_full[polarity] = 1'b0;
      if (polarity) void'(q1.pop_front());
      else          void'(q0.pop_front());
    end
    if (acc) begin
      m_full[vc] = 1'b1;
      if (vc) q1.push_back(exp_route(di));
      else    q0.push_back(exp_route(di));
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
    polarity = ~polarity;
    si = 1'b0;
    gnt = 1'b0;
    di = '0;
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b0; polarity = 1'b0; si = 1'b0; gnt = 1'b0; di = '0;
    m_full = 2'b00; m_err = 1'b0; m_cnt = 16'd0;
    #3;
    chk("rst_ri", {63'b0, ri}, 64'd1);
    chk("rst_req", {59'b0, req}, 64'd0);
    chk("rst_do_flit", do_flit, 64'd0);
    chk("rst_err", {63'b0, err_vc}, 64'd0);
    chk("rst_cnt", {48'b0, flit_cnt}, 64'd0);
    @(posedge clk); #1; reset = 1'b1; #1;

    // east hop on VC1, then grant
    di = mk(1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 40'h1111); si = 1'b1; tick();
    chk("t2_cnt", {48'b0, flit_cnt}, 64'd1);
    chk("t2_req", {59'b0, req}, 64'b00001);
    chk("t2_hx", {56'b0, do_flit[55:48]}, 64'd1);
    gnt = 1'b1; tick();
    chk("t2_ri_after_drain", {63'b0, ri}, 64'd1);

    // south hop on VC0, then a local-delivery flit
    tick();
    di = mk(1'b0, 1'b0, 1'b1, 8'd0, 8'd3, 40'h2222); si = 1'b1; tick();
    chk("t3_req_south", {59'b0, req}, 64'b01000);
    chk("t3_hy", {56'b0, do_flit[47:40]}, 64'd2);
    gnt = 1'b1; tick();
    held = mk(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 40'hABCDE);
    di = held; si = 1'b1; tick();
    chk("t3_req_pe", {59'b0, req}, 64'b10000);
    chk("t3_pe_flit", do_flit, held);
    gnt = 1'b1; tick();

    // VC1 held without grant: link sees ri=0 and a forced send is dropped
    tick();
    di = mk(1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 40'h3333); si = 1'b1; tick();
    chk("t4_req_west", {59'b0, req}, 64'b00010);
    tick();
    chk("t4_ri_blocked", {63'b0, ri}, 64'd0);
    cnt_save = flit_cnt;
    di = mk(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 40'h4444); si = 1'b1; tick();
    chk("t4_err", {63'b0, err_vc}, 64'd1);
    chk("t4_cnt_same", {48'b0, flit_cnt}, {48'b0, cnt_save});
    chk("t4_rerequest", {59'b0, req}, 64'b00010);

    // drain VC1 and write VC0 on the same edge
    gnt = 1'b1; di = mk(1'b0, 1'b0, 1'b0, 8'd4, 8'd0, 40'h5555); si = 1'b1; tick();
    chk("t5_req_vc0", {59'b0, req}, 64'b00001);
    chk("t5_ri_vc1_free", {63'b0, ri}, 64'd1);
    gnt = 1'b1; tick();
    chk("t5_vc1_empty", {59'b0, req}, 64'd0);

    // asynchronous reset with VC0 occupied
    di = mk(1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 40'h6666); si = 1'b1; tick();
    chk("t1_pre_req", {59'b0, req}, 64'b00100);
    #2; reset = 1'b0; #1;
    chk("t1_ri", {63'b0, ri}, 64'd1);
    chk("t1_req", {59'b0, req}, 64'd0);
    chk("t1_err", {63'b0, err_vc}, 64'd0);
    chk("t1_cnt", {48'b0, flit_cnt}, 64'd0);
    m_full = 2'b00; m_err = 1'b0; m_cnt = 16'd0;
    q0.delete(); q1.delete();
    #2; reset = 1'b1;
    tick();
    tick();

    // wrong VC for the current polarity
    di = mk(1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 40'h7777); si = 1'b1; tick();
    chk("t6_err", {63'b0, err_vc}, 64'd1);
    chk("t6_cnt", {48'b0, flit_cnt}, 64'd0);

    // counter saturation: one accept per cycle with continuous grant
    for (int i = 0; i < 65535; i++) begin
      di = mk(~polarity, 1'b0, 1'b0, 8'd0, 8'd0, 40'(i)); si = 1'b1; gnt = 1'b1; tick();
    end
    chk("t6_cnt_max", {48'b0, flit_cnt}, 64'h0000_0000_0000_FFFF);
    di = mk(~polarity, 1'b0, 1'b0, 8'd0, 8'd0, 40'h8888); si = 1'b1; gnt = 1'b1; tick();
    chk("t6_cnt_sat", {48'b0, flit_cnt}, 64'h0000_0000_0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
